// File: rtl/fog_demod_pkg.sv
// Shared constants and types for the fiber-optic-gyro demodulator/averager.
package fog_demod_pkg;

    localparam int ADC_W   = 14;
    localparam int HALF_W  = 16;
    localparam int ACC_W   = 48;
    localparam int LOG2_W  = 4;
    localparam int SHIFT_W = 6;
    localparam int PER_W   = 16;

    localparam int SAT_MAX = 8191;
    localparam int SAT_MIN = -8192;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2
    } state_t;

endpackage

// File: rtl/fog_sat_shift.sv
// Registered arithmetic right shift followed by saturation to a signed range.
// Loads a new result only on i_load and holds it otherwise; o_vld echoes i_load.
module fog_sat_shift
    import fog_demod_pkg::*;
#(
    parameter int IN_W    = ACC_W,
    parameter int OUT_W   = ADC_W,
    parameter int SH_W    = SHIFT_W,
    parameter int MAX_VAL = SAT_MAX,
    parameter int MIN_VAL = SAT_MIN
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic signed [IN_W-1:0]  i_data,
    input  logic [SH_W-1:0]         i_shift,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_vld
);

    localparam logic signed [IN_W-1:0] MAX_EXT = IN_W'(MAX_VAL);
    localparam logic signed [IN_W-1:0] MIN_EXT = IN_W'(MIN_VAL);

    logic signed [IN_W-1:0]  w_shifted;
    logic signed [OUT_W-1:0] w_sat;

    assign w_shifted = i_data >>> i_shift;

    // Clamp the floored value into the output range.
    always_comb begin
        w_sat = w_shifted[OUT_W-1:0];
        if (w_shifted > MAX_EXT) begin
            w_sat = OUT_W'(MAX_VAL);
        end else if (w_shifted < MIN_EXT) begin
            w_sat = OUT_W'(MIN_VAL);
        end
    end

    // Capture the result and produce the one-cycle valid strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data <= '0;
            o_vld  <= 1'b0;
        end else begin
            o_vld <= i_load;
            if (i_load) begin
                o_data <= w_sat;
            end
        end
    end

endmodule

// File: rtl/fog_demod_avg.sv
// Square-wave synchronous demodulator and frame averager feeding the Kalman
// filter: +samples in the positive half, -samples in the negative half, with
// settling samples skipped after each edge, summed over 2^avg_log2 periods.
module fog_demod_avg #(
    parameter int ADC_W  = fog_demod_pkg::ADC_W,
    parameter int HALF_W = fog_demod_pkg::HALF_W,
    parameter int ACC_W  = fog_demod_pkg::ACC_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic signed [ADC_W-1:0] i_adc,
    input  logic                    i_adc_vld,
    input  logic [HALF_W-1:0]       i_mod_half,
    input  logic [HALF_W-1:0]       i_ign,
    input  logic [3:0]              i_avg_log2,
    input  logic [5:0]              i_shift,
    output logic                    o_mod_sq,
    output logic signed [ADC_W-1:0] o_meas,
    output logic                    o_meas_vld,
    output logic                    o_err_cfg
);

    import fog_demod_pkg::*;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [HALF_W-1:0]        r_half;
    logic [HALF_W-1:0]        r_ign;
    logic [HALF_W-1:0]        r_cnt;
    logic [HALF_W-1:0]        w_cnt_nxt;
    logic [LOG2_W-1:0]        r_log2;
    logic [SHIFT_W-1:0]       r_shift;
    logic [PER_W-1:0]         r_per;
    logic [PER_W-1:0]         w_per_nxt;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic signed [ACC_W-1:0]  w_acc_step;
    logic signed [ACC_W-1:0]  w_adc_ext;
    logic                     r_mod_sq;
    logic                     w_mod_nxt;
    logic                     r_err_cfg;
    logic                     w_err_nxt;
    logic                     w_latch;
    logic                     w_fin;
    logic                     w_start;
    logic                     w_cfg_ok;
    logic                     w_last;
    logic                     w_use;
    logic                     w_per_last;

    // The legality check looks at the live inputs because it happens in the
    // same cycle they are latched.
    assign w_cfg_ok   = (i_mod_half != '0) && (i_ign < i_mod_half);
    assign w_last     = (r_cnt == r_half - HALF_W'(1));
    assign w_use      = (r_cnt >= r_ign);
    assign w_per_last = (r_per == ((PER_W'(1) << r_log2) - PER_W'(1)));
    assign w_adc_ext  = {{(ACC_W-ADC_W){i_adc[ADC_W-1]}}, i_adc};

    // Accumulator value including the current sample; also the finalize input,
    // so the last sample of a frame reaches the output without an extra stage.
    always_comb begin
        w_acc_step = r_acc;
        if (w_use) begin
            if (r_state == NEG) begin
                w_acc_step = r_acc - w_adc_ext;
            end else begin
                w_acc_step = r_acc + w_adc_ext;
            end
        end
    end

    // Next-state and datapath decisions; a frame (re)start shares one path
    // between IDLE and the back-to-back case at finalize.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_per_nxt   = r_per;
        w_acc_nxt   = r_acc;
        w_mod_nxt   = r_mod_sq;
        w_err_nxt   = r_err_cfg;
        w_latch     = 1'b0;
        w_fin       = 1'b0;
        w_start     = 1'b0;

        case (r_state)
            IDLE: begin
                w_start = 1'b1;
            end
            POS: begin
                if (!i_en) begin
                    w_state_nxt = IDLE;
                    w_mod_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_per_nxt   = '0;
                    w_acc_nxt   = '0;
                end else if (i_adc_vld) begin
                    w_acc_nxt = w_acc_step;
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = NEG;
                        w_mod_nxt   = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + HALF_W'(1);
                    end
                end
            end
            NEG: begin
                if (!i_en) begin
                    w_state_nxt = IDLE;
                    w_mod_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_per_nxt   = '0;
                    w_acc_nxt   = '0;
                end else if (i_adc_vld) begin
                    w_acc_nxt = w_acc_step;
                    if (w_last) begin
                        if (w_per_last) begin
                            w_fin   = 1'b1;
                            w_start = 1'b1;
                        end else begin
                            w_per_nxt   = r_per + PER_W'(1);
                            w_cnt_nxt   = '0;
                            w_state_nxt = POS;
                            w_mod_nxt   = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + HALF_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_mod_nxt   = 1'b0;
            end
        endcase

        if (w_start) begin
            w_cnt_nxt = '0;
            w_per_nxt = '0;
            w_acc_nxt = '0;
            if (!i_en) begin
                w_state_nxt = IDLE;
                w_mod_nxt   = 1'b0;
                w_err_nxt   = 1'b0;
            end else begin
                w_latch = 1'b1;
                if (w_cfg_ok) begin
                    w_state_nxt = POS;
                    w_mod_nxt   = 1'b1;
                    w_err_nxt   = 1'b0;
                end else begin
                    w_state_nxt = IDLE;
                    w_mod_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, accumulator, status flags and the latched frame configuration.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_per     <= '0;
            r_acc     <= '0;
            r_mod_sq  <= 1'b0;
            r_err_cfg <= 1'b0;
            r_half    <= '0;
            r_ign     <= '0;
            r_log2    <= '0;
            r_shift   <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_per     <= w_per_nxt;
            r_acc     <= w_acc_nxt;
            r_mod_sq  <= w_mod_nxt;
            r_err_cfg <= w_err_nxt;
            if (w_latch) begin
                r_half  <= i_mod_half;
                r_ign   <= i_ign;
                r_log2  <= i_avg_log2;
                r_shift <= i_shift;
            end
        end
    end

    fog_sat_shift #(
        .IN_W    (ACC_W),
        .OUT_W   (ADC_W),
        .SH_W    (SHIFT_W),
        .MAX_VAL (SAT_MAX),
        .MIN_VAL (SAT_MIN)
    ) u_sat_shift (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_fin),
        .i_data  (w_acc_step),
        .i_shift (r_shift),
        .o_data  (o_meas),
        .o_vld   (o_meas_vld)
    );

    assign o_mod_sq  = r_mod_sq;
    assign o_err_cfg = r_err_cfg;

endmodule

// File: tb/tb_fog_demod_avg.sv
// Self-checking bench for fog_demod_avg: table-driven frames, hand-written
// corner sequences and randomized frames against a behavioural model.
module tb_fog_demod_avg;

    import fog_demod_pkg::*;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_en;
    logic signed [13:0] i_adc;
    logic               i_adc_vld;
    logic [15:0]        i_mod_half;
    logic [15:0]        i_ign;
    logic [3:0]         i_avg_log2;
    logic [5:0]         i_shift;
    logic               o_mod_sq;
    logic signed [13:0] o_meas;
    logic               o_meas_vld;
    logic               o_err_cfg;

    int checks    = 0;
    int failures  = 0;
    int sampleCnt = 0;
    int lastMeas  = 0;
    int strobeVal[$];
    int strobeAt[$];
    int modelQ[$];

    typedef struct {
        string name;
        int    half;
        int    ign;
        int    log2;
        int    shift;
        int    posVal;
        int    negVal;
        int    stall;
        int    expMeas;
    } vec_t;

    vec_t tbl[8];

    fog_demod_avg dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_adc      (i_adc),
        .i_adc_vld  (i_adc_vld),
        .i_mod_half (i_mod_half),
        .i_ign      (i_ign),
        .i_avg_log2 (i_avg_log2),
        .i_shift    (i_shift),
        .o_mod_sq   (o_mod_sq),
        .o_meas     (o_meas),
        .o_meas_vld (o_meas_vld),
        .o_err_cfg  (o_err_cfg)
    );

    // 100 MHz clock.
    always #5 i_clk = ~i_clk;

    // Record every strobe with the number of samples accepted so far.
    always @(negedge i_clk) begin
        if (o_meas_vld) begin
            strobeVal.push_back(int'(o_meas));
            strobeAt.push_back(sampleCnt);
        end
    end

    // Hard stop if the bench ever stalls.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one valid sample, optionally preceded by a stall cycle carrying junk.
    task automatic applyStimulus(input int val, input bit stall);
        if (stall) begin
            i_adc_vld = 1'b0;
            i_adc     = 14'($urandom);
            @(posedge i_clk);
            #1;
        end
        i_adc     = 14'(val);
        i_adc_vld = 1'b1;
        @(posedge i_clk);
        sampleCnt++;
        #1;
        i_adc_vld = 1'b0;
    endtask

    // Frame result from the demodulation rules: sign by half, skip settling
    // samples, floor shift, clamp.
    function automatic int modelFrame(input int q[$], input int half, input int ign, input int shift);
        longint sum = 0;
        for (int k = 0; k < q.size(); k++) begin
            int pos = k % (2 * half);
            if ((pos % half) >= ign) begin
                if (pos < half) sum = sum + longint'(q[k]);
                else            sum = sum - longint'(q[k]);
            end
        end
        sum = sum >>> shift;
        if (sum > longint'(SAT_MAX)) return SAT_MAX;
        if (sum < longint'(SAT_MIN)) return SAT_MIN;
        return int'(sum);
    endfunction

    task automatic clearRecords();
        strobeVal.delete();
        strobeAt.delete();
        modelQ.delete();
        sampleCnt = 0;
    endtask

    // Run nFrames back-to-back frames with i_en held, then drop i_en.
    // stallMode: 0 none, 1 every sample, 2 random.
    task automatic runFrames(input int half, input int ign, input int log2, input int shift,
                             input int posVal, input int negVal, input bit rnd,
                             input int stallMode, input int nFrames);
        int total;
        int v;
        int vals[$];
        bit st;
        total = 2 * half * (1 << log2);
        clearRecords();
        i_mod_half = 16'(half);
        i_ign      = 16'(ign);
        i_avg_log2 = 4'(log2);
        i_shift    = 6'(shift);
        i_adc_vld  = 1'b0;
        i_en       = 1'b1;
        @(posedge i_clk);
        #1;
        checkOutput("mod_sq at frame start", int'(o_mod_sq), 1);
        for (int f = 0; f < nFrames; f++) begin
            vals.delete();
            for (int k = 0; k < total; k++) begin
                if (rnd) begin
                    v = int'($urandom_range(0, 16383)) - 8192;
                    if ($urandom_range(0, 1) == 1) v = v / 64;
                end else begin
                    v = ((k % (2 * half)) < half) ? posVal : negVal;
                end
                vals.push_back(v);
                st = (stallMode == 1) || ((stallMode == 2) && ($urandom_range(0, 2) == 0));
                applyStimulus(v, st);
                checkOutput($sformatf("mod_sq after sample %0d", k), int'(o_mod_sq),
                            ((k + 1 == total) || (((k + 1) % (2 * half)) < half)) ? 1 : 0);
            end
            modelQ.push_back(modelFrame(vals, half, ign, shift));
        end
        i_en = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("mod_sq after disable", int'(o_mod_sq), 0);
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    initial begin
        int half;
        int ign;
        int log2;
        int shift;
        int nFr;
        int total;

        tbl[0] = '{"basic",      4, 1, 0, 0,   100,  -100, 0,   600};
        tbl[1] = '{"avg_stall",  2, 0, 2, 3,    10,     0, 1,    10};
        tbl[2] = '{"sat_pos",    4, 0, 0, 0,  8000, -8000, 0,  8191};
        tbl[3] = '{"sat_neg",    4, 0, 0, 0, -8000,  8000, 0, -8192};
        tbl[4] = '{"floor_neg",  1, 0, 0, 1,    -2,     1, 0,    -2};
        tbl[5] = '{"floor_pos",  1, 0, 0, 1,     3,     0, 0,     1};
        tbl[6] = '{"ign_heavy",  5, 4, 1, 0,     7,    -7, 0,    28};
        tbl[7] = '{"shift_neg",  3, 0, 1, 2,    -5,     6, 0,   -17};

        i_rst      = 1'b1;
        i_en       = 1'b0;
        i_adc      = '0;
        i_adc_vld  = 1'b0;
        i_mod_half = '0;
        i_ign      = '0;
        i_avg_log2 = '0;
        i_shift    = '0;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("reset o_mod_sq", int'(o_mod_sq), 0);
        checkOutput("reset o_meas", int'(o_meas), 0);
        checkOutput("reset o_meas_vld", int'(o_meas_vld), 0);
        checkOutput("reset o_err_cfg", int'(o_err_cfg), 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        $display("[TB] config error sequence");
        clearRecords();
        i_mod_half = 16'd4;
        i_ign      = 16'd4;
        i_en       = 1'b1;
        @(posedge i_clk);
        #1;
        checkOutput("cfg err set", int'(o_err_cfg), 1);
        checkOutput("cfg err mod_sq", int'(o_mod_sq), 0);
        i_adc_vld = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_adc_vld = 1'b0;
        checkOutput("cfg err held", int'(o_err_cfg), 1);
        checkOutput("cfg err mod_sq held", int'(o_mod_sq), 0);
        checkOutput("cfg err strobes", strobeVal.size(), 0);
        i_ign = 16'd1;
        @(posedge i_clk);
        #1;
        checkOutput("cfg err cleared", int'(o_err_cfg), 0);
        checkOutput("cfg fixed frame start", int'(o_mod_sq), 1);
        i_mod_half = 16'd0;
        i_ign      = 16'd0;
        i_en       = 1'b0;
        @(posedge i_clk);
        #1;
        i_en = 1'b1;
        @(posedge i_clk);
        #1;
        checkOutput("cfg half zero err", int'(o_err_cfg), 1);
        i_en = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("cfg err cleared by disable", int'(o_err_cfg), 0);

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            total = 2 * tbl[i].half * (1 << tbl[i].log2);
            runFrames(tbl[i].half, tbl[i].ign, tbl[i].log2, tbl[i].shift,
                      tbl[i].posVal, tbl[i].negVal, 1'b0, tbl[i].stall, 1);
            checkOutput({tbl[i].name, " strobe count"}, strobeVal.size(), 1);
            if (strobeVal.size() > 0) begin
                checkOutput({tbl[i].name, " o_meas"}, strobeVal[0], tbl[i].expMeas);
                checkOutput({tbl[i].name, " strobe position"}, strobeAt[0], total);
            end
            lastMeas = tbl[i].expMeas;
        end

        $display("[TB] abort during NEG");
        clearRecords();
        i_mod_half = 16'd4;
        i_ign      = 16'd1;
        i_avg_log2 = 4'd0;
        i_shift    = 6'd0;
        i_en       = 1'b1;
        @(posedge i_clk);
        #1;
        for (int k = 0; k < 6; k++) applyStimulus((k < 4) ? 100 : -100, 1'b0);
        i_en      = 1'b0;
        i_adc     = -14'sd100;
        i_adc_vld = 1'b1;
        @(posedge i_clk);
        #1;
        i_adc_vld = 1'b0;
        checkOutput("abort mod_sq", int'(o_mod_sq), 0);
        repeat (4) @(posedge i_clk);
        #1;
        checkOutput("abort strobes", strobeVal.size(), 0);
        checkOutput("abort o_meas held", int'(o_meas), lastMeas);

        $display("[TB] back-to-back frames");
        runFrames(4, 1, 0, 0, 100, -100, 1'b0, 0, 3);
        checkOutput("b2b strobe count", strobeVal.size(), 3);
        for (int j = 0; j < strobeVal.size() && j < 3; j++) begin
            checkOutput($sformatf("b2b o_meas %0d", j), strobeVal[j], 600);
            checkOutput($sformatf("b2b strobe position %0d", j), strobeAt[j], 8 * (j + 1));
        end

        $display("[TB] reset during POS");
        clearRecords();
        i_en = 1'b1;
        @(posedge i_clk);
        #1;
        applyStimulus(100, 1'b0);
        applyStimulus(100, 1'b0);
        i_rst = 1'b1;
        i_en  = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("midrst o_mod_sq", int'(o_mod_sq), 0);
        checkOutput("midrst o_meas", int'(o_meas), 0);
        checkOutput("midrst o_meas_vld", int'(o_meas_vld), 0);
        checkOutput("midrst o_err_cfg", int'(o_err_cfg), 0);
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("midrst strobes", strobeVal.size(), 0);

        $display("[TB] randomized frames");
        for (int r = 0; r < 12; r++) begin
            half  = int'($urandom_range(1, 6));
            ign   = int'($urandom_range(0, half - 1));
            log2  = int'($urandom_range(0, 2));
            shift = int'($urandom_range(0, 8));
            nFr   = int'($urandom_range(1, 2));
            total = 2 * half * (1 << log2);
            runFrames(half, ign, log2, shift, 0, 0, 1'b1, 2, nFr);
            checkOutput($sformatf("rand %0d strobe count", r), strobeVal.size(), nFr);
            for (int j = 0; j < strobeVal.size() && j < nFr; j++) begin
                checkOutput($sformatf("rand %0d o_meas %0d", r, j), strobeVal[j], modelQ[j]);
                checkOutput($sformatf("rand %0d strobe position %0d", r, j), strobeAt[j], total * (j + 1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
